block_reverse: RTL and testbench



---
 rtl/block_reverse_pkg.sv | 16 +
 rtl/ram_2port.sv | 39 +++
 rtl/block_reverse.sv | 151 +++++++++++++++
 tb/tb_block_reverse.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/block_reverse_pkg.sv
// Shared definitions for the block reversal utility: reader FSM encoding
// and block-size helper.
package block_reverse_pkg;

  // Reader FSM states
  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  // Block length in samples for a given log2 size
  function automatic int unsigned block_size(input int unsigned shift);
    return 32'd1 << shift;
  endfunction

endpackage : block_reverse_pkg

// File: rtl/ram_2port.sv
// Simple dual-port RAM: port A write-only, port B read-only with a
// registered (1-clock) read. Contents are not reset.
module ram_2port #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned AWIDTH = 5
) (
  input  logic              clka,
  input  logic              ena,
  input  logic              wea,
  input  logic [AWIDTH-1:0] addra,
  input  logic [DWIDTH-1:0] dia,
  input  logic              clkb,
  input  logic              enb,
  input  logic [AWIDTH-1:0] addrb,
  output logic [DWIDTH-1:0] dob
);

  localparam int unsigned DEPTH = 32'd1 << AWIDTH;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] dob_q;

  // Port A write
  always_ff @(posedge clka) begin
    if (ena && wea) begin
      mem_q[addra] <= dia;
    end
  end

  // Port B registered read
  always_ff @(posedge clkb) begin
    if (enb) begin
      dob_q <= mem_q[addrb];
    end
  end

  assign dob = dob_q;

endmodule : ram_2port

// File: rtl/block_reverse.sv
// Block reversal: gathers 2^BLOCK_SHIFT valid samples into one RAM bank
// while the other bank is drained in descending address order, so each
// block leaves last-in first-out. Ping-pong banks give gapless output at
// one sample per clock.
// Optional: define BLOCK_REVERSE_LAST_EN to add the output_last port,
// flagging the output cycle that carries original sample 0 of a block.
module block_reverse
  import block_reverse_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned BLOCK_SHIFT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  input_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  output_valid,
  output logic                  busy
`ifdef BLOCK_REVERSE_LAST_EN
  ,
  output logic                  output_last
`endif
);

  localparam int unsigned BLOCK_N = block_size(BLOCK_SHIFT);
  localparam int unsigned RAM_AW  = BLOCK_SHIFT + 1;
  localparam logic [BLOCK_SHIFT-1:0] LAST_ADDR = BLOCK_SHIFT'(BLOCK_N - 1);

  // Write side
  logic [BLOCK_SHIFT-1:0] wr_addr_q, wr_addr_d;
  logic                   wr_bank_q, wr_bank_d;
  logic                   wr_en_c;
  logic                   blk_done_c;
  logic                   blk_bank_c;

  // Read side
  rd_state_e              state_q, state_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [BLOCK_SHIFT-1:0] rd_addr_q, rd_addr_d;
  logic                   rd_en_c;
  logic                   output_valid_q;

  // Write enable and end-of-block detection; blk_done is combinational so
  // the reader can start on the very edge that stores the last sample.
  always_comb begin
    wr_en_c    = enable & input_valid;
    blk_done_c = wr_en_c && (wr_addr_q == LAST_ADDR);
    blk_bank_c = wr_bank_q;
  end

  // Write address / bank advance
  always_comb begin
    wr_addr_d = wr_addr_q;
    wr_bank_d = wr_bank_q;
    if (wr_en_c) begin
      wr_addr_d = wr_addr_q + BLOCK_SHIFT'(1);
      if (blk_done_c) begin
        wr_bank_d = ~wr_bank_q;
      end
    end
  end

  // Reader next-state: drain one address per enabled cycle, reload on
  // the final address if another block completes in the same cycle.
  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    rd_addr_d = rd_addr_q;
    rd_en_c   = 1'b0;
    if (enable) begin
      case (state_q)
        RD_IDLE: begin
          if (blk_done_c) begin
            state_d   = RD_READ;
            rd_bank_d = blk_bank_c;
            rd_addr_d = LAST_ADDR;
          end
        end
        RD_READ: begin
          rd_en_c = 1'b1;
          if (rd_addr_q == '0) begin
            if (blk_done_c) begin
              rd_bank_d = blk_bank_c;
              rd_addr_d = LAST_ADDR;
            end else begin
              state_d = RD_IDLE;
            end
          end else begin
            rd_addr_d = rd_addr_q - BLOCK_SHIFT'(1);
          end
        end
        default: state_d = RD_IDLE;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_addr_q      <= '0;
      wr_bank_q      <= 1'b0;
      state_q        <= RD_IDLE;
      rd_bank_q      <= 1'b0;
      rd_addr_q      <= '0;
      output_valid_q <= 1'b0;
    end else begin
      wr_addr_q      <= wr_addr_d;
      wr_bank_q      <= wr_bank_d;
      state_q        <= state_d;
      rd_bank_q      <= rd_bank_d;
      rd_addr_q      <= rd_addr_d;
      output_valid_q <= rd_en_c;
    end
  end

`ifdef BLOCK_REVERSE_LAST_EN
  logic output_last_q;

  // Flag the read of address 0, aligned with output_valid
  always_ff @(posedge clock) begin
    if (reset) begin
      output_last_q <= 1'b0;
    end else begin
      output_last_q <= rd_en_c && (rd_addr_q == '0);
    end
  end

  assign output_last = output_last_q;
`endif

  ram_2port #(
    .DWIDTH(DATA_WIDTH),
    .AWIDTH(RAM_AW)
  ) u_ram (
    .clka (clock),
    .ena  (wr_en_c),
    .wea  (1'b1),
    .addra({wr_bank_q, wr_addr_q}),
    .dia  (data_in),
    .clkb (clock),
    .enb  (rd_en_c),
    .addrb({rd_bank_q, rd_addr_q}),
    .dob  (data_out)
  );

  assign output_valid = output_valid_q;
  assign busy         = (state_q == RD_READ);

endmodule : block_reverse

// File: tb/tb_block_reverse.sv
// Directed bench for block_reverse with N=4, 16-bit samples.
module tb_block_reverse;
  import block_reverse_pkg::*;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [15:0] data_in;
  logic        input_valid;
  logic [15:0] data_out;
  logic        output_valid;
  logic        busy;
  logic        last_w;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int drive_cyc = 0;
  int busy_cnt = 0;
  int overrun_cnt = 0;

  logic [15:0] mon_data [$];
  int          mon_cyc  [$];
  logic        mon_last [$];

  block_reverse #(
    .DATA_WIDTH (16),
    .BLOCK_SHIFT(2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .data_in     (data_in),
    .input_valid (input_valid),
    .data_out    (data_out),
    .output_valid(output_valid),
    .busy        (busy)
`ifdef BLOCK_REVERSE_LAST_EN
    ,
    .output_last (last_w)
`endif
  );

`ifndef BLOCK_REVERSE_LAST_EN
  assign last_w = 1'b0;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Record outputs, busy cycles and overrun conditions away from the edge
  always @(negedge clock) begin
    if (output_valid === 1'b1) begin
      mon_data.push_back(data_out);
      mon_cyc.push_back(cyc);
      mon_last.push_back(last_w);
    end
    if (busy === 1'b1) busy_cnt++;
    if (!reset && dut.blk_done_c && dut.state_q == RD_READ && dut.rd_addr_q != 2'd0)
      overrun_cnt++;
  end

  task automatic drive(input logic en, input logic vld, input logic [15:0] d);
    @(posedge clock);
    #1;
    enable      = en;
    input_valid = vld;
    data_in     = d;
    drive_cyc   = cyc;
  endtask

  task automatic mon_clear();
    mon_data.delete();
    mon_cyc.delete();
    mon_last.delete();
    busy_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; input_valid = 1'b1; data_in = 16'hdead;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if (output_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", output_valid); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef BLOCK_REVERSE_LAST_EN
    n_cmp++;
    if (last_w !== 1'b0) begin n_bad++; $display("FAIL reset_last got=%b exp=0", last_w); end
`endif
    @(posedge clock); #1;
    reset = 1'b0; enable = 1'b1; input_valid = 1'b0; data_in = '0;
    repeat (2) drive(1'b1, 1'b0, 16'd0);
    n_cmp++;
    if (mon_data.size() != 0) begin n_bad++; $display("FAIL reset_no_output got=%0d exp=0", mon_data.size()); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d [8];
    logic        exp_l [8];
    int c4;
    exp_d = '{16'd4, 16'd3, 16'd2, 16'd1, 16'd8, 16'd7, 16'd6, 16'd5};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    c4 = 0;
    mon_clear();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 16'(i + 1));
      if (i == 3) c4 = drive_cyc;
    end
    repeat (8) drive(1'b1, 1'b0, 16'd0);
    n_cmp++;
    if (mon_data.size() != 8) begin n_bad++; $display("FAIL b2b_count got=%0d exp=8", mon_data.size()); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (i >= mon_data.size()) begin
        n_bad++; $display("FAIL b2b_missing idx=%0d exp=%0d", i, exp_d[i]);
      end else begin
        if (mon_data[i] !== exp_d[i]) begin n_bad++; $display("FAIL b2b_data idx=%0d got=%0d exp=%0d", i, mon_data[i], exp_d[i]); end
        n_cmp++;
        if (mon_cyc[i] != c4 + 2 + i) begin n_bad++; $display("FAIL b2b_cycle idx=%0d got=%0d exp=%0d", i, mon_cyc[i], c4 + 2 + i); end
`ifdef BLOCK_REVERSE_LAST_EN
        n_cmp++;
        if (mon_last[i] !== exp_l[i]) begin n_bad++; $display("FAIL b2b_last idx=%0d got=%b exp=%b", i, mon_last[i], exp_l[i]); end
`endif
      end
    end
  endtask

  task automatic test_gapped();
    logic [15:0] exp_d [4];
    int c4;
    exp_d = '{16'd4, 16'd3, 16'd2, 16'd1};
    mon_clear();
    drive(1'b1, 1'b1, 16'd1);
    drive(1'b1, 1'b0, 16'd0);
    drive(1'b1, 1'b1, 16'd2);
    drive(1'b1, 1'b0, 16'd0);
    drive(1'b1, 1'b0, 16'd0);
    drive(1'b1, 1'b1, 16'd3);
    drive(1'b1, 1'b1, 16'd4);
    c4 = drive_cyc;
    repeat (8) drive(1'b1, 1'b0, 16'd0);
    n_cmp++;
    if (mon_data.size() != 4) begin n_bad++; $display("FAIL gap_count got=%0d exp=4", mon_data.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= mon_data.size()) begin
        n_bad++; $display("FAIL gap_missing idx=%0d exp=%0d", i, exp_d[i]);
      end else begin
        if (mon_data[i] !== exp_d[i]) begin n_bad++; $display("FAIL gap_data idx=%0d got=%0d exp=%0d", i, mon_data[i], exp_d[i]); end
        n_cmp++;
        if (mon_cyc[i] != c4 + 2 + i) begin n_bad++; $display("FAIL gap_cycle idx=%0d got=%0d exp=%0d", i, mon_cyc[i], c4 + 2 + i); end
      end
    end
    n_cmp++;
    if (busy_cnt != 4) begin n_bad++; $display("FAIL gap_busy got=%0d exp=4", busy_cnt); end
  endtask

  task automatic test_enable_stall();
    logic [15:0] exp_d [4];
    int          exp_o [4];
    int c4;
    exp_d = '{16'd4, 16'd3, 16'd2, 16'd1};
    exp_o = '{2, 3, 7, 8};
    mon_clear();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 16'(i + 1));
    c4 = drive_cyc;
    drive(1'b1, 1'b0, 16'd0);
    drive(1'b1, 1'b0, 16'd0);
    repeat (3) drive(1'b0, 1'b0, 16'd0);
    repeat (8) drive(1'b1, 1'b0, 16'd0);
    n_cmp++;
    if (mon_data.size() != 4) begin n_bad++; $display("FAIL stall_count got=%0d exp=4", mon_data.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= mon_data.size()) begin
        n_bad++; $display("FAIL stall_missing idx=%0d exp=%0d", i, exp_d[i]);
      end else begin
        if (mon_data[i] !== exp_d[i]) begin n_bad++; $display("FAIL stall_data idx=%0d got=%0d exp=%0d", i, mon_data[i], exp_d[i]); end
        n_cmp++;
        if (mon_cyc[i] != c4 + exp_o[i]) begin n_bad++; $display("FAIL stall_cycle idx=%0d got=%0d exp=%0d", i, mon_cyc[i], c4 + exp_o[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp_d [4];
    int c13;
    exp_d = '{16'd13, 16'd12, 16'd11, 16'd10};
    mon_clear();
    drive(1'b1, 1'b1, 16'd1);
    drive(1'b1, 1'b1, 16'd2);
    @(posedge clock); #1;
    reset = 1'b1; input_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 16'(10 + i));
    c13 = drive_cyc;
    repeat (8) drive(1'b1, 1'b0, 16'd0);
    n_cmp++;
    if (mon_data.size() != 4) begin n_bad++; $display("FAIL rstmid_count got=%0d exp=4", mon_data.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= mon_data.size()) begin
        n_bad++; $display("FAIL rstmid_missing idx=%0d exp=%0d", i, exp_d[i]);
      end else begin
        if (mon_data[i] !== exp_d[i]) begin n_bad++; $display("FAIL rstmid_data idx=%0d got=%0d exp=%0d", i, mon_data[i], exp_d[i]); end
        n_cmp++;
        if (mon_cyc[i] != c13 + 2 + i) begin n_bad++; $display("FAIL rstmid_cycle idx=%0d got=%0d exp=%0d", i, mon_cyc[i], c13 + 2 + i); end
      end
    end
  endtask

  task automatic test_bank_wrap();
    int c3;
    logic [15:0] exp;
    c3 = 0;
    mon_clear();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 16'(100 + i));
      if (i == 3) c3 = drive_cyc;
    end
    repeat (8) drive(1'b1, 1'b0, 16'd0);
    n_cmp++;
    if (mon_data.size() != 16) begin n_bad++; $display("FAIL wrap_count got=%0d exp=16", mon_data.size()); end
    for (int i = 0; i < 16; i++) begin
      exp = 16'(100 + 4 * (i / 4) + 3 - (i % 4));
      n_cmp++;
      if (i >= mon_data.size()) begin
        n_bad++; $display("FAIL wrap_missing idx=%0d exp=%0d", i, exp);
      end else begin
        if (mon_data[i] !== exp) begin n_bad++; $display("FAIL wrap_data idx=%0d got=%0d exp=%0d", i, mon_data[i], exp); end
        n_cmp++;
        if (mon_cyc[i] != c3 + 2 + i) begin n_bad++; $display("FAIL wrap_cycle idx=%0d got=%0d exp=%0d", i, mon_cyc[i], c3 + 2 + i); end
      end
    end
    n_cmp++;
    if (overrun_cnt != 0) begin n_bad++; $display("FAIL overrun got=%0d exp=0", overrun_cnt); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; input_valid = 1'b0; data_in = '0;
    test_reset();
    test_back_to_back();
    test_gapped();
    test_enable_stall();
    test_reset_mid();
    test_bank_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_block_reverse
